// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC constants for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_MISS = 2'd2
  } fs_t;
  localparam logic [31:0] PC_INCR = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [15:0] MISS_MAX = 16'hFFFF;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect/hazard inputs and instruction-memory/IF-ID outputs of the fetch stage
interface fetch_if;
  logic [31:0] adr_branch;
  logic        PCSrc;
  logic        stall;
  logic        hit;
  logic [31:0] Ins_address;
  logic [31:0] Add_out;
  logic        fetch_valid;
  logic        flush;
  logic [15:0] miss_cycles;
  modport master (
    input  adr_branch, PCSrc, stall, hit,
    output Ins_address, Add_out, fetch_valid, flush, miss_cycles
  );
  modport slave (
    output adr_branch, PCSrc, stall, hit,
    input  Ins_address, Add_out, fetch_valid, flush, miss_cycles
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux; a live redirect beats a pending one, which beats hold/advance
module pc_next_sel import fetch_pkg::*; (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] adr_branch,
  input  logic [31:0] pend_target,
  input  logic        take_branch,
  input  logic        take_pend,
  input  logic        hold,
  output logic [31:0] next_pc
);
  always_comb begin
    next_pc = take_branch ? (adr_branch & ALIGN_MASK) :
              take_pend   ? (pend_target & ALIGN_MASK) :
              hold        ? pc : pc_plus4;
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC register and BOOT/RUN/MISS sequencing of instruction fetch
module fetch_controller import fetch_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  fs_t state, state_n;
  logic [31:0] pc, pc_n, pc_plus4, pend_target;
  logic [15:0] miss_cnt;
  logic pend_valid, take_branch, take_pend, hold, fv, fl, pend_set, pend_clr;
  assign pc_plus4 = pc + PC_INCR;
  pc_next_sel u_sel (
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .adr_branch  (bus.adr_branch),
    .pend_target (pend_target),
    .take_branch (take_branch),
    .take_pend   (take_pend),
    .hold        (hold),
    .next_pc     (pc_n)
  );
  always_comb begin
    state_n = state;
    take_branch = 1'b0;
    take_pend = 1'b0;
    hold = 1'b1;
    fv = 1'b0;
    fl = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state)
      FS_BOOT: state_n = FS_RUN;
      FS_RUN: begin
        if (bus.PCSrc) begin
          take_branch = 1'b1;
          fl = 1'b1;
        end else if (!bus.hit) begin
          state_n = FS_MISS;
        end else if (!bus.stall) begin
          hold = 1'b0;
          fv = 1'b1;
        end
      end
      FS_MISS: begin
        if (bus.hit) begin
          state_n = FS_RUN;
          pend_clr = 1'b1;
          if (bus.PCSrc) begin
            take_branch = 1'b1;
            fl = 1'b1;
          end else if (pend_valid) begin
            take_pend = 1'b1;
            fl = 1'b1;
          end else if (!bus.stall) begin
            hold = 1'b0;
            fv = 1'b1;
          end
        end else if (bus.PCSrc) begin
          pend_set = 1'b1;
          fl = 1'b1;
        end
      end
      default: state_n = FS_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_BOOT;
      pc <= RESET_VECTOR;
      pend_valid <= 1'b0;
      pend_target <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (pend_set) begin
        pend_target <= bus.adr_branch;
        pend_valid <= 1'b1;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (state == FS_MISS && miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 16'd1;
    end
  end
  assign bus.Ins_address = pc;
  assign bus.Add_out = pc_plus4;
  assign bus.fetch_valid = fv & ~rst;
  assign bus.flush = fl & ~rst;
  assign bus.miss_cycles = miss_cnt;
endmodule
